// File: rtl/rv_pkg.sv
// Shared RV32 register-file definitions: widths and the writeback arbiter state encoding.
package rv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_WAIT  = 2'd1,
        WB_FORCE = 2'd2
    } wb_fsm_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit array for x1..x31 with one set port, one clear port and three lookups.
module reg_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_rd
);

    logic [31:1] busy_q, busy_d;
    logic [31:0] busy_vec;

    // Bit 0 is hard-wired idle so x0 lookups never stall.
    assign busy_vec = {busy_q, 1'b0};

    assign busy_rs1 = busy_vec[rs1];
    assign busy_rs2 = busy_vec[rs2];
    assign busy_rd  = busy_vec[rd];

    // Clear first, then set, so a same-cycle set on the same bit wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en && clr_addr != '0) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en && set_addr != '0) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and one long-latency unit,
// with hazard scoreboard. Define WB_STARVE_EN to enable the anti-starvation forced slot.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic                  iss_long,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    input  logic [REG_ADDR_W-1:0] chk_rd,
    output logic                  stall,
    input  logic                  pwb_we,
    input  logic [REG_ADDR_W-1:0] pwb_addr,
    input  logic [XLEN-1:0]       pwb_data,
    input  logic                  lwb_valid,
    input  logic [REG_ADDR_W-1:0] lwb_addr,
    input  logic [XLEN-1:0]       lwb_data,
    output logic                  lwb_ready,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Wt_addr,
    output logic [XLEN-1:0]       Wt_data
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range_err
        $error("STARVE_MAX must be in 1..15");
    end

    logic pwb_req;
    logic pwb_eff;
    logic lwb_xfer;
    logic force_slot;
    logic busy_rs1, busy_rs2, busy_rd;
    logic sb_set;

    assign pwb_req   = pwb_we && (pwb_addr != '0);
    assign pwb_eff   = pwb_req && !force_slot;
    assign lwb_ready = !rst && lwb_valid && (!pwb_eff || force_slot);
    assign lwb_xfer  = lwb_valid && lwb_ready;

    // A long transfer to x0 still consumes the slot but leaves the port idle.
    always_comb begin
        RegWrite = 1'b0;
        Wt_addr  = '0;
        Wt_data  = '0;
        if (lwb_xfer) begin
            if (lwb_addr != '0) begin
                RegWrite = 1'b1;
                Wt_addr  = lwb_addr;
                Wt_data  = lwb_data;
            end
        end else if (pwb_eff && !rst) begin
            RegWrite = 1'b1;
            Wt_addr  = pwb_addr;
            Wt_data  = pwb_data;
        end
    end

    assign stall  = !rst && (busy_rs1 || busy_rs2 || busy_rd || force_slot);
    assign sb_set = iss_valid && !stall && iss_long;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_addr (iss_rd),
        .clr_en   (lwb_xfer),
        .clr_addr (lwb_addr),
        .rs1      (chk_rs1),
        .rs2      (chk_rs2),
        .rd       (chk_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

`ifdef WB_STARVE_EN
    localparam logic [3:0] starve_lim = 4'(STARVE_MAX);

    wb_fsm_e    state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    assign force_slot = (state_q == WB_FORCE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (lwb_xfer) begin
            state_d = WB_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WB_IDLE: begin
                    if (lwb_valid) begin
                        cnt_d   = 4'd1;
                        state_d = (starve_lim <= 4'd1) ? WB_FORCE : WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (lwb_valid) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d >= starve_lim) begin
                            state_d = WB_FORCE;
                        end
                    end else begin
                        state_d = WB_IDLE;
                        cnt_d   = '0;
                    end
                end
                // Only reachable if the long unit withdrew valid, which it must not.
                WB_FORCE: begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    a_no_pwb_in_force: assert property (@(posedge clk) disable iff (rst)
        !(state_q == WB_FORCE && pwb_we));
`else
    assign force_slot = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter; expectations follow WB_STARVE_EN when defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_long;
    logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic        stall;
    logic        pwb_we;
    logic [4:0]  pwb_addr;
    logic [31:0] pwb_data;
    logic        lwb_valid;
    logic [4:0]  lwb_addr;
    logic [31:0] lwb_data;
    logic        lwb_ready;
    logic        RegWrite;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_long  (iss_long),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .stall     (stall),
        .pwb_we    (pwb_we),
        .pwb_addr  (pwb_addr),
        .pwb_data  (pwb_data),
        .lwb_valid (lwb_valid),
        .lwb_addr  (lwb_addr),
        .lwb_data  (lwb_data),
        .lwb_ready (lwb_ready),
        .RegWrite  (RegWrite),
        .Wt_addr   (Wt_addr),
        .Wt_data   (Wt_data)
    );

    typedef struct packed {
        logic        r;
        logic        iv;
        logic        il;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_stall;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    function automatic vec_t v(input logic r, iv, il, input logic [4:0] ird, rs1, rs2, rd,
                               input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld,
                               input logic es, er, ew, input logic [4:0] ea,
                               input logic [31:0] ed);
        vec_t t;
        t = '{r: r, iv: iv, il: il, ird: ird, rs1: rs1, rs2: rs2, rd: rd,
              pwe: pwe, pa: pa, pd: pd, lv: lv, la: la, ld: ld,
              e_stall: es, e_rdy: er, e_we: ew, e_addr: ea, e_data: ed};
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, vec_idx, act, want);
        end
    endtask

    task automatic step(input vec_t t);
        rst       = t.r;
        iss_valid = t.iv;
        iss_long  = t.il;
        iss_rd    = t.ird;
        chk_rs1   = t.rs1;
        chk_rs2   = t.rs2;
        chk_rd    = t.rd;
        pwb_we    = t.pwe;
        pwb_addr  = t.pa;
        pwb_data  = t.pd;
        lwb_valid = t.lv;
        lwb_addr  = t.la;
        lwb_data  = t.ld;
        exp_q.push_back(t);
        @(negedge clk);
        begin
            vec_t e;
            e = exp_q.pop_front();
            cmp("stall", {31'b0, stall}, {31'b0, e.e_stall});
            cmp("lwb_ready", {31'b0, lwb_ready}, {31'b0, e.e_rdy});
            cmp("RegWrite", {31'b0, RegWrite}, {31'b0, e.e_we});
            cmp("Wt_addr", {27'b0, Wt_addr}, {27'b0, e.e_addr});
            cmp("Wt_data", Wt_data, e.e_data);
        end
        @(posedge clk);
        #1;
        vec_idx++;
    endtask

    initial begin
        int n_block;
        rst = 1'b1; iss_valid = 0; iss_long = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        pwb_we = 0; pwb_addr = 0; pwb_data = 0;
        lwb_valid = 0; lwb_addr = 0; lwb_data = 0;
        @(posedge clk);
        #1;

        // Reset: outputs idle, lwb_valid and pwb_we ignored.
        tbl.push_back(v(1,0,0,0, 0,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(1,0,0,0, 0,0,0, 1,7,32'h11,     1,9,32'h22,     0,0,0,0,0));
        // Long op to x5, RAW stall, stalled issue ignored, writeback clears.
        tbl.push_back(v(0,1,1,5, 0,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,1,1,6, 5,0,0, 0,0,0,          0,0,0,          1,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,5,6, 0,0,0,          0,0,0,          1,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,6, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 5,0,0, 0,0,0,          1,5,32'hDEADBEEF, 1,1,1,5,32'hDEADBEEF));
        tbl.push_back(v(0,0,0,0, 5,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h1234,   0,0,0,          0,0,1,7,32'h1234));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,0,32'h55,     0,0,0,          0,0,0,0,0));
        // pwb to x0 does not block; lwb to x0 writes nothing and clears nothing.
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,0,32'h55,     1,9,32'hA5A5,   0,1,1,9,32'hA5A5));
        tbl.push_back(v(0,1,1,4, 0,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 4,0,0, 0,0,0,          1,0,32'h77,     1,1,0,0,0));
        tbl.push_back(v(0,0,0,0, 4,0,0, 0,0,0,          0,0,0,          1,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 4,0,0, 1,7,32'h8,      1,4,32'h44,     1,0,1,7,32'h8));
        tbl.push_back(v(0,0,0,0, 4,0,0, 0,0,0,          1,4,32'h44,     1,1,1,4,32'h44));
        tbl.push_back(v(0,0,0,0, 4,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        // Same-cycle set and clear of x3: set wins.
        tbl.push_back(v(0,1,1,3, 0,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,1,1,3, 0,0,0, 0,0,0,          1,3,32'h33,     0,1,1,3,32'h33));
        tbl.push_back(v(0,0,0,0, 3,0,0, 0,0,0,          0,0,0,          1,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 3,0,0, 0,0,0,          1,3,32'h34,     1,1,1,3,32'h34));
        tbl.push_back(v(0,0,0,0, 3,0,0, 0,0,0,          0,0,0,          0,0,0,0,0));

        // Starvation: pipeline keeps the port busy while x9 waits.
`ifdef WB_STARVE_EN
        n_block = 4;
`else
        n_block = 20;
`endif
        for (int k = 0; k < n_block; k++) begin
            tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h70 + k, 1,9,32'h99, 0,0,1,7,32'h70 + k));
        end
`ifdef WB_STARVE_EN
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,          1,9,32'h99,     1,1,1,9,32'h99));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h80,     0,0,0,          0,0,1,7,32'h80));
`else
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,          1,9,32'h99,     0,1,1,9,32'h99));
`endif

        // Reset mid-operation: busy x10/x11, FSM waiting on x12.
        tbl.push_back(v(0,1,1,10, 0,0,0, 0,0,0,         0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,1,1,11, 0,0,0, 0,0,0,         0,0,0,          0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h1,      1,12,32'hC,     0,0,1,7,32'h1));
        tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h1,      1,12,32'hC,     0,0,1,7,32'h1));
        tbl.push_back(v(1,0,0,0, 10,0,0, 1,7,32'h1,     1,12,32'hC,     0,0,0,0,0));
        tbl.push_back(v(0,0,0,0, 10,11,0, 0,0,0,        0,0,0,          0,0,0,0,0));
        // Counter restarted from 0: three blocked cycles must not force.
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(v(0,0,0,0, 0,0,0, 1,7,32'h2,  1,12,32'hC,     0,0,1,7,32'h2));
        end
        tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,0,          1,12,32'hC,     0,1,1,12,32'hC));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
